// File: rtl/bel_fft_pkg.sv
`default_nettype none
// ============================================================================
// bel_fft_pkg : shared FFT post-processing types, saturation limits, overflow helper
// Revision    : 1.0
// ============================================================================
package bel_fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } cacc_state_t;

  // Limits are returned 64 bits wide; callers cast down to their accumulator width.
  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    sat_min = ~64'd0 << (w - 1);
  endfunction

  // The two MSBs of a one-bit-extended signed result disagree exactly on overflow.
  function automatic logic signed_ovf(input logic [1:0] msbs);
    signed_ovf = msbs[1] ^ msbs[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bel_cacc_if.sv
`default_nettype none
// ============================================================================
// bel_cacc_if : sample input / result output bundle of the complex accumulator
// Revision    : 1.0
// ============================================================================
interface bel_cacc_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8
);
  logic                          start_i;
  logic [COUNT_WIDTH-1:0]        len_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic signed [WORD_WIDTH-1:0]  a_re_i;
  logic signed [WORD_WIDTH-1:0]  a_im_i;
  logic                          sub_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic signed [ACC_WIDTH-1:0]   x_re_o;
  logic signed [ACC_WIDTH-1:0]   x_im_o;
  logic                          busy_o;
  logic                          ovf_o;

  modport master (
    output start_i, len_i, in_valid_i, a_re_i, a_im_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, x_re_o, x_im_o, busy_o, ovf_o
  );

  modport slave (
    input  start_i, len_i, in_valid_i, a_re_i, a_im_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, x_re_o, x_im_o, busy_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/bel_cacc_lane.sv
`default_nettype none
// ============================================================================
// bel_cacc_lane : one real accumulator lane, add/sub with signed overflow detect
//                 BEL_CACC_SAT_EN selects clamping instead of wrap on overflow
// Revision      : 1.0
// ============================================================================
module bel_cacc_lane
  import bel_fft_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         i_clr,
  input  wire logic                         i_en,
  input  wire logic                         i_sub,
  input  wire logic signed [WORD_WIDTH-1:0] i_sample,
  output logic signed [ACC_WIDTH-1:0]       o_acc,
  output logic                              o_ovf
);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [ACC_WIDTH:0]   w_ext;
  logic        [ACC_WIDTH:0]   w_acc_ext;
  logic        [ACC_WIDTH:0]   w_sum;
  logic        [ACC_WIDTH-1:0] w_next;

  assign w_ext     = {{(ACC_WIDTH + 1 - WORD_WIDTH){i_sample[WORD_WIDTH-1]}}, i_sample};
  assign w_acc_ext = {r_acc[ACC_WIDTH-1], r_acc};
  assign w_sum     = i_sub ? (w_acc_ext - w_ext) : (w_acc_ext + w_ext);
  assign o_ovf     = signed_ovf(w_sum[ACC_WIDTH -: 2]);

`ifdef BEL_CACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] c_max = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] c_min = ACC_WIDTH'(sat_min(ACC_WIDTH));

  // The true sign of the result is the extra MSB, which picks the rail.
  assign w_next = !o_ovf ? w_sum[ACC_WIDTH-1:0] : (w_sum[ACC_WIDTH] ? c_min : c_max);
`else
  assign w_next = w_sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/bel_cacc.sv
`default_nettype none
// ============================================================================
// bel_cacc : sequential complex accumulator with valid/ready result port
//            optional clamping on overflow via BEL_CACC_SAT_EN
// Revision : 1.0
// ============================================================================
module bel_cacc
  import bel_fft_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8
) (
  input  wire logic   clk_i,
  input  wire logic   rst_n_i,
  bel_cacc_if.slave   bus
);

  cacc_state_t            r_state;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_ovf;
  logic                   w_clr;
  logic                   w_xfer;
  logic                   w_ovf_re;
  logic                   w_ovf_im;
  logic [ACC_WIDTH-1:0]   w_acc_re;
  logic [ACC_WIDTH-1:0]   w_acc_im;

  assign w_clr  = (r_state == ST_IDLE) && bus.start_i;
  assign w_xfer = bus.in_valid_i && r_in_ready;

  bel_cacc_lane #(.WORD_WIDTH(WORD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_re (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .i_clr    (w_clr),
    .i_en     (w_xfer),
    .i_sub    (bus.sub_i),
    .i_sample (bus.a_re_i),
    .o_acc    (w_acc_re),
    .o_ovf    (w_ovf_re)
  );

  bel_cacc_lane #(.WORD_WIDTH(WORD_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_im (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .i_clr    (w_clr),
    .i_en     (w_xfer),
    .i_sub    (bus.sub_i),
    .i_sample (bus.a_im_i),
    .o_acc    (w_acc_im),
    .o_ovf    (w_ovf_im)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_cnt  <= bus.len_i;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
            if (bus.len_i != '0) begin
              r_state    <= ST_ACC;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (w_xfer) begin
            r_cnt <= r_cnt - 1'b1;
            r_ovf <= r_ovf | w_ovf_re | w_ovf_im;
            if (r_cnt == COUNT_WIDTH'(1)) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.busy_o      = r_busy;
  assign bus.ovf_o       = r_ovf;
  assign bus.x_re_o      = w_acc_re;
  assign bus.x_im_o      = w_acc_im;

endmodule
`default_nettype wire

// File: tb/tb_bel_cacc.sv
`default_nettype none
// ============================================================================
// tb_bel_cacc : directed self-checking bench for bel_cacc (24-bit and 17-bit builds)
// Revision    : 1.0
// ============================================================================
module tb_bel_cacc;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bel_cacc_if #(.WORD_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(8)) bus   ();
  bel_cacc_if #(.WORD_WIDTH(16), .ACC_WIDTH(17), .COUNT_WIDTH(8)) bus17 ();

  bel_cacc #(.WORD_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(8)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  bel_cacc #(.WORD_WIDTH(16), .ACC_WIDTH(17), .COUNT_WIDTH(8)) u_dut17 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus17.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i = 0; bus.len_i = '0; bus.in_valid_i = 0; bus.a_re_i = '0;
    bus.a_im_i = '0; bus.sub_i = 0; bus.out_ready_i = 0;
    bus17.start_i = 0; bus17.len_i = '0; bus17.in_valid_i = 0; bus17.a_re_i = '0;
    bus17.a_im_i = '0; bus17.sub_i = 0; bus17.out_ready_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.ovf_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.ovf_o});
    end
    n_checks++;
    if (bus.x_re_o !== 24'sd0 || bus.x_im_o !== 24'sd0) begin
      n_errors++;
      $display("FAIL reset_x: got (%0d,%0d) expected (0,0)", bus.x_re_o, bus.x_im_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.start_i = 1; bus.len_i = 8'd4;
    tick();
    bus.start_i = 0;
    n_checks++;
    if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready_after_start: got rdy=%b busy=%b expected 1 1",
               bus.in_ready_o, bus.busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1; bus.sub_i = 0;
      bus.a_re_i = 16'(2 * i + 1); bus.a_im_i = 16'(2 * i + 2);
      tick();
      // out_valid must stay low until the fourth sample is taken
      if (i < 3) begin
        n_checks++;
        if (bus.out_valid_o !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_early_valid: sample %0d got %b expected 0", i, bus.out_valid_o);
        end
      end
    end
    bus.in_valid_i = 0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_done: got vld=%b rdy=%b expected 1 0", bus.out_valid_o, bus.in_ready_o);
    end
    n_checks++;
    if (bus.x_re_o !== 24'sd16 || bus.x_im_o !== 24'sd20 || bus.ovf_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_sum: got (%0d,%0d) ovf=%b expected (16,20) ovf=0",
               bus.x_re_o, bus.x_im_o, bus.ovf_o);
    end
    bus.out_ready_i = 1;
    tick();
    bus.out_ready_i = 0;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_release: got busy=%b vld=%b expected 0 0", bus.busy_o, bus.out_valid_o);
    end
  endtask

  task automatic test_gaps_and_stall();
    bus.start_i = 1; bus.len_i = 8'd3;
    tick();
    bus.start_i = 0;
    bus.in_valid_i = 1; bus.sub_i = 0; bus.a_re_i = 16'sd100; bus.a_im_i = -16'sd50;
    tick();
    bus.in_valid_i = 0;
    tick(); tick();
    bus.in_valid_i = 1; bus.sub_i = 1; bus.a_re_i = 16'sd30; bus.a_im_i = 16'sd10;
    tick();
    bus.in_valid_i = 0;
    tick();
    bus.in_valid_i = 1; bus.sub_i = 0; bus.a_re_i = -16'sd5; bus.a_im_i = 16'sd5;
    tick();
    // junk sample offered while the result is held must not be absorbed
    bus.a_re_i = 16'sd1000; bus.a_im_i = 16'sd1000;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.x_re_o !== 24'sd65 || bus.x_im_o !== -24'sd55) begin
        n_errors++;
        $display("FAIL gap_hold: cycle %0d got vld=%b (%0d,%0d) expected 1 (65,-55)",
                 i, bus.out_valid_o, bus.x_re_o, bus.x_im_o);
      end
      tick();
    end
    bus.in_valid_i = 0;
    bus.out_ready_i = 1;
    tick();
    bus.out_ready_i = 0;
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL gap_release: got vld=%b busy=%b expected 0 0", bus.out_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_len_zero_and_ignored_start();
    bus.start_i = 1; bus.len_i = 8'd0;
    tick();
    // start held high with a new length while DONE
    bus.len_i = 8'd5;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 ||
        bus.x_re_o !== 24'sd0 || bus.x_im_o !== 24'sd0) begin
      n_errors++;
      $display("FAIL len0: got vld=%b rdy=%b (%0d,%0d) expected 1 0 (0,0)",
               bus.out_valid_o, bus.in_ready_o, bus.x_re_o, bus.x_im_o);
    end
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL len0_start_in_done: got vld=%b rdy=%b expected 1 0",
               bus.out_valid_o, bus.in_ready_o);
    end
    bus.start_i = 0; bus.out_ready_i = 1;
    tick();
    bus.out_ready_i = 0;
    bus.start_i = 1; bus.len_i = 8'd2;
    tick();
    bus.start_i = 1; bus.len_i = 8'd7;
    bus.in_valid_i = 1; bus.sub_i = 0; bus.a_re_i = 16'sd1; bus.a_im_i = 16'sd1;
    tick();
    bus.start_i = 0;
    bus.a_re_i = 16'sd2; bus.a_im_i = 16'sd2;
    tick();
    bus.in_valid_i = 0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.x_re_o !== 24'sd3 || bus.x_im_o !== 24'sd3) begin
      n_errors++;
      $display("FAIL start_in_acc: got vld=%b (%0d,%0d) expected 1 (3,3)",
               bus.out_valid_o, bus.x_re_o, bus.x_im_o);
    end
    bus.out_ready_i = 1;
    tick();
    bus.out_ready_i = 0;
  endtask

  task automatic test_overflow();
    bus17.start_i = 1; bus17.len_i = 8'd3;
    tick();
    bus17.start_i = 0;
    for (int i = 0; i < 3; i++) begin
      bus17.in_valid_i = 1; bus17.sub_i = 0;
      bus17.a_re_i = 16'sd32767; bus17.a_im_i = -16'sd32768;
      tick();
      if (i == 1) begin
        n_checks++;
        if (bus17.ovf_o !== 1'b0) begin
          n_errors++;
          $display("FAIL ovf_early: got %b expected 0", bus17.ovf_o);
        end
      end
    end
    bus17.in_valid_i = 0;
    n_checks++;
    if (bus17.ovf_o !== 1'b1 || bus17.out_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_flag: got ovf=%b vld=%b expected 1 1", bus17.ovf_o, bus17.out_valid_o);
    end
`ifdef BEL_CACC_SAT_EN
    n_checks++;
    if (bus17.x_re_o !== 17'sd65535 || bus17.x_im_o !== -17'sd65536) begin
      n_errors++;
      $display("FAIL ovf_sat: got (%0d,%0d) expected (65535,-65536)", bus17.x_re_o, bus17.x_im_o);
    end
`else
    n_checks++;
    if (bus17.x_re_o !== -17'sd32771 || bus17.x_im_o !== 17'sd32768) begin
      n_errors++;
      $display("FAIL ovf_wrap: got (%0d,%0d) expected (-32771,32768)", bus17.x_re_o, bus17.x_im_o);
    end
`endif
    bus17.out_ready_i = 1;
    tick();
    bus17.out_ready_i = 0;
    bus17.start_i = 1; bus17.len_i = 8'd0;
    tick();
    bus17.start_i = 0;
    n_checks++;
    if (bus17.ovf_o !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_clear_on_start: got %b expected 0", bus17.ovf_o);
    end
    bus17.out_ready_i = 1;
    tick();
    bus17.out_ready_i = 0;
  endtask

  task automatic test_reset_mid_run();
    bus.start_i = 1; bus.len_i = 8'd4;
    tick();
    bus.start_i = 0;
    bus.in_valid_i = 1; bus.sub_i = 0; bus.a_re_i = 16'sd1; bus.a_im_i = 16'sd2;
    tick();
    bus.a_re_i = 16'sd3; bus.a_im_i = 16'sd4;
    tick();
    bus.in_valid_i = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.ovf_o} !== 4'b0000 ||
        bus.x_re_o !== 24'sd0 || bus.x_im_o !== 24'sd0) begin
      n_errors++;
      $display("FAIL mid_reset: got flags=%b (%0d,%0d) expected 0000 (0,0)",
               {bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.ovf_o},
               bus.x_re_o, bus.x_im_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.start_i = 1; bus.len_i = 8'd1;
    tick();
    bus.start_i = 0;
    bus.in_valid_i = 1; bus.sub_i = 0; bus.a_re_i = 16'sd9; bus.a_im_i = -16'sd9;
    tick();
    bus.in_valid_i = 0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.x_re_o !== 24'sd9 || bus.x_im_o !== -24'sd9) begin
      n_errors++;
      $display("FAIL post_reset_run: got vld=%b (%0d,%0d) expected 1 (9,-9)",
               bus.out_valid_o, bus.x_re_o, bus.x_im_o);
    end
    bus.out_ready_i = 1;
    tick();
    bus.out_ready_i = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_back_to_back();
    test_gaps_and_stall();
    test_len_zero_and_ignored_start();
    test_overflow();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
